// File: rtl/gf180mcu_osu_sc_9t_clkdiv_ctrl.sv
// Glitch-free programmable clock divider with a phase-aligned ratio-load handshake.
// Ratio changes and stops are deferred to the end of a low phase so Y never emits a runt pulse.
module gf180mcu_osu_sc_9t_clkdiv_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DIV_RST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD_REQ,
  input  logic [WIDTH-1:0] DIV_IN,
  output logic             Y,
  output logic             LD_ACK,
  output logic             BUSY,
  output logic             STOPPED
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ACT_RST = WIDTH'(DIV_RST);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg,   cnt_next;
  logic [WIDTH-1:0] act_reg,   act_next;
  logic [WIDTH-1:0] pend_reg,  pend_next;
  logic             y_reg,     y_next;
  logic             busy_reg,  busy_next;
  logic             ack_reg,   ack_next;

  logic at_top;
  logic low_end;
  logic accept;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    act_next   = act_reg;
    pend_next  = pend_reg;
    y_next     = y_reg;
    busy_next  = busy_reg;
    ack_next   = 1'b0;

    at_top  = (cnt_reg == act_reg);
    low_end = (state_reg == RUN) && !y_reg && at_top;
    accept  = LD_REQ && !busy_reg;

    // A new request is only taken when nothing is pending, so this never
    // collides with the busy clear performed when a pending ratio is applied.
    if (accept) begin
      pend_next = DIV_IN;
      busy_next = 1'b1;
    end

    case (state_reg)
      STOP: begin
        if (busy_reg) begin
          act_next  = pend_reg;
          busy_next = 1'b0;
          ack_next  = 1'b1;
        end
        if (EN) begin
          state_next = RUN;
          y_next     = 1'b1;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (low_end) begin
          if (busy_reg) begin
            act_next  = pend_reg;
            busy_next = 1'b0;
            ack_next  = 1'b1;
          end
          cnt_next = '0;
          if (EN) begin
            y_next = 1'b1;
          end else begin
            state_next = STOP;
            y_next     = 1'b0;
          end
        end else if (at_top) begin
          cnt_next = '0;
          y_next   = ~y_reg;
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= STOP;
      cnt_reg   <= '0;
      act_reg   <= ACT_RST;
      pend_reg  <= '0;
      y_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      pend_reg  <= pend_next;
      y_reg     <= y_next;
      busy_reg  <= busy_next;
      ack_reg   <= ack_next;
    end
  end

  assign Y       = y_reg;
  assign LD_ACK  = ack_reg;
  assign BUSY    = busy_reg;
  assign STOPPED = (state_reg == STOP);

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkdiv_ctrl.sv
// Scenario bench for the clock divider: each task queues the expected {Y,LD_ACK,BUSY,STOPPED}
// per cycle as it drives stimulus, then pops and compares once the edge has happened.
module tb_gf180mcu_osu_sc_9t_clkdiv_ctrl;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             LD_REQ = 1'b0;
  logic [WIDTH-1:0] DIV_IN = '0;
  logic             Y;
  logic             LD_ACK;
  logic             BUSY;
  logic             STOPPED;

  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  gf180mcu_osu_sc_9t_clkdiv_ctrl #(.WIDTH(WIDTH), .DIV_RST(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LD_REQ(LD_REQ), .DIV_IN(DIV_IN),
    .Y(Y), .LD_ACK(LD_ACK), .BUSY(BUSY), .STOPPED(STOPPED)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; LD_REQ = 1'b0; DIV_IN = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Reset from power-up, then reset held while EN and LD_REQ are asserted.
  task automatic test_reset();
    logic [3:0] e, g;
    for (int k = 1; k <= 2; k++) begin
      RST = 1'b1; EN = (k == 2); LD_REQ = (k == 2); DIV_IN = 4'd9;
      exp_q.push_back(4'b0001);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
    RST = 1'b0; EN = 1'b0; LD_REQ = 1'b0;
  endtask

  // Default ratio 1: Y rises the edge after EN, then 1,1,0,0 repeating.
  task automatic test_run_default();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      EN = 1'b1;
      exp_q.push_back({((k - 1) % 4) < 2, 3'b000});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL run_default k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
  endtask

  // Load each ratio in STOP and start on the same edge that applies it.
  task automatic test_ratios();
    logic [3:0] e, g;
    int ratios[3] = '{2, 6, 15};
    for (int i = 0; i < 3; i++) begin
      int r = ratios[i];
      do_reset();
      for (int k = 1; k <= 2 + 4 * (r + 1); k++) begin
        LD_REQ = (k == 1); DIV_IN = 4'(r); EN = (k >= 2);
        if (k == 1)      exp_q.push_back(4'b0011);
        else if (k == 2) exp_q.push_back(4'b1100);
        else             exp_q.push_back({((k - 2) % (2 * (r + 1))) < (r + 1), 3'b000});
        @(posedge CLK); #1;
        e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL ratio_%0d k=%0d got y/ack/busy/stopped=%b expected %b", r, k, g, e);
        end
      end
    end
  endtask

  // Load ratio 3 in the first high cycle while running at ratio 1.
  task automatic test_load_running();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      EN = 1'b1; LD_REQ = (k == 2); DIV_IN = 4'd3;
      if (k == 1)      exp_q.push_back(4'b1000);
      else if (k == 2) exp_q.push_back(4'b1010);
      else if (k <= 4) exp_q.push_back(4'b0010);
      else if (k == 5) exp_q.push_back(4'b1100);
      else             exp_q.push_back({((k - 5) % 8) < 4, 3'b000});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_running k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
    LD_REQ = 1'b0;
  endtask

  // EN dropped in the first high cycle: both phases complete, then parked low.
  task automatic test_stop();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      EN = (k == 1);
      exp_q.push_back({k <= 2, 2'b00, k >= 5});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL stop k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
  endtask

  // Ratio 0 loaded in STOP, second request during BUSY dropped, then divide-by-2.
  task automatic test_load_in_stop();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      LD_REQ = (k <= 2); DIV_IN = (k == 1) ? 4'd0 : 4'd7; EN = (k >= 3);
      if (k == 1)      exp_q.push_back(4'b0011);
      else if (k == 2) exp_q.push_back(4'b0101);
      else             exp_q.push_back({((k - 3) % 2) == 0, 3'b000});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_in_stop k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
  endtask

  // Reset at the end of a high phase while a load is pending.
  task automatic test_reset_mid();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      EN = 1'b1; LD_REQ = (k == 2); DIV_IN = 4'd5; RST = (k == 3);
      if (k == 1)      exp_q.push_back(4'b1000);
      else if (k == 2) exp_q.push_back(4'b1010);
      else if (k == 3) exp_q.push_back(4'b0001);
      else             exp_q.push_back({((k - 4) % 4) < 2, 3'b000});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
    RST = 1'b0; LD_REQ = 1'b0;
  endtask

  // EN pulses low in a low phase and in a high phase, restored before the boundary.
  task automatic test_en_glitch();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      EN = !(k == 4 || k == 6);
      exp_q.push_back({((k - 1) % 4) < 2, 3'b000});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL en_glitch k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
  endtask

  // Requests on consecutive cycles: the one during BUSY drops, the one after ACK lands.
  task automatic test_back_to_back();
    logic [3:0] e, g;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      LD_REQ = (k <= 3); EN = (k >= 4);
      DIV_IN = (k == 1) ? 4'd6 : ((k == 2) ? 4'd0 : 4'd2);
      if (k == 1)      exp_q.push_back(4'b0011);
      else if (k == 2) exp_q.push_back(4'b0101);
      else if (k == 3) exp_q.push_back(4'b0011);
      else if (k == 4) exp_q.push_back(4'b1100);
      else             exp_q.push_back({((k - 4) % 6) < 3, 3'b000});
      @(posedge CLK); #1;
      e = exp_q.pop_front(); g = {Y, LD_ACK, BUSY, STOPPED};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back k=%0d got y/ack/busy/stopped=%b expected %b", k, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_default();
    test_ratios();
    test_load_running();
    test_stop();
    test_load_in_stop();
    test_reset_mid();
    test_en_glitch();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_9t_clkdiv_ctrl.md
GF180MCU_OSU_SC_9T_CLKDIV_CTRL -- requirements
Module: gf180mcu_osu_sc_9T_clkdiv_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the divide-ratio field width.
REQ-002 The block SHALL have parameter DIV_RST, default 1, giving the active ratio after reset.
REQ-003 The block SHALL have port CLK  input  1  source clock; single clock domain, all state updates on rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port EN  input  1  divided-clock run request.
REQ-006 The block SHALL have port LD_REQ  input  1  ratio-load request, sampled with DIV_IN.
REQ-007 The block SHALL have port DIV_IN  input  WIDTH  requested ratio value.
REQ-008 The block SHALL have port Y  output  1  registered divided clock, driving the downstream clock buffer.
REQ-009 The block SHALL have port LD_ACK  output  1  one-cycle pulse, new ratio now active.
REQ-010 The block SHALL have port BUSY  output  1  a load is pending.
REQ-011 The block SHALL have port STOPPED  output  1  Y is parked low in STOP state.

Function
REQ-012 The block SHALL hold internal state: state {STOP, RUN}, counter cnt (WIDTH bits), active ratio act, pending ratio pend.
REQ-013 In RUN, Y SHALL hold each phase for act+1 CLK cycles (period 2*(act+1), 50% duty); DIV value 0 gives divide-by-2.
REQ-014 In RUN, each cycle: if cnt==act then cnt<=0 and Y<=~Y, else cnt<=cnt+1.
REQ-015 A low-end boundary SHALL be defined as RUN && Y==0 && cnt==act, i.e. the cycle before Y would rise.
REQ-016 At a low-end boundary with BUSY=1, act SHALL take pend, BUSY SHALL clear, and LD_ACK SHALL be 1 the next cycle.
REQ-017 At a low-end boundary with EN=0, the block SHALL enter STOP with Y=0, cnt=0 and STOPPED=1, instead of raising Y.
REQ-018 Ratio change and stop SHALL occur only at low-end boundaries, so no high or low phase is ever truncated or lengthened mid-phase.
REQ-019 In STOP with EN=1, the next edge SHALL set Y=1, cnt=0, state RUN and STOPPED=0.
REQ-020 In STOP with BUSY=1, the next edge SHALL apply pend to act and pulse LD_ACK, regardless of EN.
REQ-021 When STOP applies a pending ratio and exits on the same edge, the new act SHALL govern the first high phase.
REQ-022 LD_REQ=1 with BUSY=0 SHALL capture DIV_IN into pend and set BUSY=1 from the next cycle.
REQ-023 LD_REQ while BUSY=1 SHALL be ignored, leaving pend unchanged and producing no extra LD_ACK.
REQ-024 LD_ACK SHALL be high for exactly one cycle per accepted request and low otherwise.
REQ-025 BUSY SHALL fall on the same edge that raises LD_ACK.
REQ-026 EN deasserting during a high phase SHALL let that high phase and the following low phase complete before STOP.
REQ-027 EN reasserting before the boundary SHALL cancel the stop.

Reset
REQ-028 RST=1 SHALL force, on the next edge, state=STOP, Y=0, cnt=0, act=DIV_RST, pend=0, BUSY=0, LD_ACK=0 and STOPPED=1.
REQ-029 RST SHALL take priority over EN and LD_REQ, and a pending load SHALL be discarded without LD_ACK.
REQ-030 Truncation of the current phase by RST SHALL be permitted.

Verification
REQ-031 Default reset, then EN=1 -> Y=1 the next cycle, then repeating 1,1,0,0 (period 4), with STOPPED=0.
REQ-032 Running act=1, LD_REQ with DIV_IN=3 in the first high cycle -> BUSY=1 until the low-end boundary, then LD_ACK for 1 cycle, then Y 4 high / 4 low, with no phase shorter than 2 cycles.
REQ-033 Running act=1, EN=0 in the first high cycle -> Y completes 2 high and 2 low, then stays 0, with STOPPED=1 from the boundary edge.
REQ-034 In STOP, LD_REQ with DIV_IN=0 -> BUSY=1 for 1 cycle and LD_ACK the next cycle; a second LD_REQ with DIV_IN=7 during BUSY is dropped; then EN=1 -> Y toggles every cycle.
REQ-035 RST=1 mid high phase with BUSY=1 -> next cycle Y=0, STOPPED=1, BUSY=0, no LD_ACK, and act=DIV_RST.
REQ-036 EN=0 then EN=1 in the same low phase -> no stop; the period stays unchanged.
